// File: rtl/nibble_scan_mux_if.sv
// Signal bundle for the scanned display multiplexer: channel data and controls in,
// strobe, data and frame marker out.
interface nibble_scan_mux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  // No valid/ready handshake: inputs are sampled every cycle and outputs are
  // continuously valid registers (channelSel is the live index register).
  logic                      enable;
  logic [CHANNELS*WIDTH-1:0] dataIn;
  logic [CHANNELS-1:0]       blankMask;
  logic                      manualMode;
  logic [SEL_W-1:0]          manualSel;
  logic [WIDTH-1:0]          dataOut;
  logic [CHANNELS-1:0]       anodeN;
  logic [SEL_W-1:0]          channelSel;
  logic                      frameStart;

  modport master (
    output enable, dataIn, blankMask, manualMode, manualSel,
    input  dataOut, anodeN, channelSel, frameStart
  );

  modport slave (
    input  enable, dataIn, blankMask, manualMode, manualSel,
    output dataOut, anodeN, channelSel, frameStart
  );
endinterface

// File: rtl/nibble_scan_mux.sv
// Time-multiplexed display driver: steps through CHANNELS inputs, DIVIDE cycles each,
// blanking the first DEAD cycles of every slot to avoid ghosting between digits.
module nibble_scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DIVIDE   = 100000,
  parameter int DEAD     = 1000
) (
  input logic              clk,
  input logic              reset,
  nibble_scan_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int PW    = $clog2(DIVIDE);
  localparam int DW    = $clog2(DEAD + 2);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
  localparam logic [PW-1:0]    LAST_PRE = PW'(DIVIDE - 1);

  logic [PW-1:0]    prescaler;
  logic [SEL_W-1:0] index;
  logic [DW-1:0]    deadCount;
  logic [WIDTH-1:0] dataOutQ;
  logic [CHANNELS-1:0] anodeNQ;
  logic             frameStartQ;

  logic             tick;
  logic             display;
  logic             manualOk;
  logic [WIDTH-1:0] channelVal;

  always_comb begin
    tick       = 1'b0;
    display    = 1'b0;
    manualOk   = 1'b0;
    channelVal = bus.dataIn[index*WIDTH +: WIDTH];
    tick       = bus.enable && !bus.manualMode && (prescaler == LAST_PRE);
    display    = bus.enable && (deadCount == '0) && !bus.blankMask[index];
    manualOk   = int'(bus.manualSel) < CHANNELS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler   <= '0;
      index       <= '0;
      deadCount   <= DW'(DEAD);
      dataOutQ    <= '0;
      anodeNQ     <= '1;
      frameStartQ <= 1'b0;
    end else begin
      // Outputs load from pre-edge state, giving one cycle of latency.
      frameStartQ <= tick && (index == LAST_IDX);
      if (display) begin
        dataOutQ <= channelVal;
        anodeNQ  <= ~(CHANNELS'(1) << index);
      end else begin
        dataOutQ <= '0;
        anodeNQ  <= '1;
      end

      if (bus.enable) begin
        if (bus.manualMode) begin
          prescaler <= '0;
          if (manualOk && (bus.manualSel != index)) begin
            index     <= bus.manualSel;
            deadCount <= DW'(DEAD);
          end else if (deadCount != '0) begin
            deadCount <= deadCount - 1'b1;
          end
        end else if (tick) begin
          prescaler <= '0;
          index     <= (index == LAST_IDX) ? '0 : index + 1'b1;
          deadCount <= DW'(DEAD);
        end else begin
          prescaler <= prescaler + 1'b1;
          if (deadCount != '0) deadCount <= deadCount - 1'b1;
        end
      end
    end
  end

  assign bus.dataOut    = dataOutQ;
  assign bus.anodeN     = anodeNQ;
  assign bus.channelSel = index;
  assign bus.frameStart = frameStartQ;
endmodule

// File: doc/nibble_scan_mux.md
NIBBLE_SCAN_MUX -- requirements
Module: nibble_scan_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the bits per channel (legal: 1 and above).
REQ-002 The block SHALL have parameter CHANNELS, default 4, setting the number of input channels (legal: 2 and above); SEL_W = clog2(CHANNELS).
REQ-003 The block SHALL have parameter DIVIDE, default 100000, setting the clock cycles each channel is displayed (legal: 2 and above).
REQ-004 The block SHALL have parameter DEAD, default 1000, setting the anti-ghost blank cycles at the start of each channel slot (legal: 0 to DIVIDE-1).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, reset; it is synchronous and active-high.
REQ-007 The block SHALL have port enable, input, 1 bit; 1 = scanning and display active.
REQ-008 The block SHALL have port dataIn, input, CHANNELS*WIDTH bits; channel i is dataIn[i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port blankMask, input, CHANNELS bits; bit i = 1 suppresses channel i.
REQ-010 The block SHALL have port manualMode, input, 1 bit; 1 = fixed channel, no scanning.
REQ-011 The block SHALL have port manualSel, input, SEL_W bits; the channel used in manual mode.
REQ-012 The block SHALL have port dataOut, output, WIDTH bits, registered; the selected channel value.
REQ-013 The block SHALL have port anodeN, output, CHANNELS bits, registered; active-low one-hot channel strobe.
REQ-014 The block SHALL have port channelSel, output, SEL_W bits; the current channel index register.
REQ-015 The block SHALL have port frameStart, output, 1 bit, registered; one-cycle pulse on scan wrap.

Function
REQ-016 The block SHALL hold internal state: prescaler (0..DIVIDE-1), index (0..CHANNELS-1) and deadCount (0..DEAD).
REQ-017 The prescaler SHALL increment only while enable=1 and manualMode=0; at DIVIDE-1 it returns to 0 and raises the slot tick.
REQ-018 On a slot tick: index <= index+1, wrapping to 0 after CHANNELS-1; deadCount <= DEAD.
REQ-019 A tick with index=CHANNELS-1 SHALL set frameStart=1 for exactly the next cycle; frameStart=0 otherwise.
REQ-020 If deadCount is nonzero and there is no tick, deadCount SHALL decrement by 1 each cycle while enable=1.
REQ-021 While enable=0: prescaler, index and deadCount hold; anodeN=all ones; dataOut=0; frameStart=0.
REQ-022 When manualMode=1 and manualSel<CHANNELS: index <= manualSel each cycle; prescaler <= 0; no frameStart.
REQ-023 When manualMode=1 and manualSel>=CHANNELS: index holds its previous value.
REQ-024 A change of index in manual mode SHALL load deadCount=DEAD.
REQ-025 When manualMode falls 1->0, scanning SHALL resume from the current index with prescaler=0.
REQ-026 Each cycle the output registers SHALL load from pre-edge state, giving one cycle of latency from index/dataIn/blankMask to the outputs.
REQ-027 Display condition: enable=1, deadCount=0 and blankMask[index]=0.
REQ-028 When the display condition holds: dataOut <= channel[index]; anodeN <= ~(1<<index).
REQ-029 When the display condition does not hold: dataOut <= 0; anodeN <= all ones.
REQ-030 anodeN SHALL never have more than one bit low in any cycle.
REQ-031 channelSel SHALL equal the index register directly, with no extra delay.

Reset
REQ-032 reset=1 SHALL, on the next edge, set prescaler=0, index=0, deadCount=DEAD, dataOut=0, anodeN=all ones, channelSel=0 and frameStart=0.
REQ-033 Reset SHALL take priority over enable, manualMode and any in-progress tick, including reset asserted mid-slot.

Verification (bench parameters: WIDTH=4, CHANNELS=4, DIVIDE=4, DEAD=1)
REQ-034 Scan: reset, then enable=1 -> channelSel steps 0,1,2,3,0 every 4 cycles; frameStart is one cycle high immediately after 3->0.
REQ-035 Data/strobe: dataIn=16'hDCBA, blankMask=0 -> per slot, after 1 dead cycle plus 1 latency cycle: (dataOut=A, anodeN=1110), (B, 1101), (C, 1011), (D, 0111).
REQ-036 Blank: blankMask=4'b0010 -> throughout slot 1, anodeN=1111 and dataOut=0; the other slots are unchanged.
REQ-037 Manual: manualMode=1, manualSel=2 -> steady dataOut=C, anodeN=1011, no frameStart; after release, the next step is 2->3 after 4 cycles.
REQ-038 Reset mid-scan: reset during slot 2 -> next cycle channelSel=0, anodeN=1111, dataOut=0, frameStart=0.
REQ-039 Freeze: enable=0 for 10 cycles mid-slot -> anodeN=1111 and channelSel is held; on re-enable, the slot completes its remaining prescaler count.
